rr_mux8to1_16bit: RTL and testbench

Eight-channel round-robin collector: the return path of `mux8to1_16bit`, which fans one 16-bit word out to `out1..out8` by `sel`. This block gathers words from eight producers into one registered stream with valid/ready handshakes. It tags each word with the 3-bit source index, using the same encoding as the demux `sel`, so a downstream demux can route replies back. One output register; one word per cycle sustained.

---
 rtl/mux_pkg.sv | 25 ++
 rtl/rr_mux8to1_16bit_if.sv | 40 ++++
 rtl/rr_arbiter8.sv | 39 +++
 rtl/rr_mux8to1_16bit.sv | 69 ++++++
 tb/tb_rr_mux8to1_16bit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the 8-channel mux/demux pair.
// The select encoding is common to both blocks.
package mux_pkg;

    localparam int N_CH          = 8;
    localparam int SEL_W         = 3;
    localparam int DEFAULT_WIDTH = 16;

    localparam logic [SEL_W-1:0] SEL_CH1 = 3'b000;
    localparam logic [SEL_W-1:0] SEL_CH2 = 3'b001;
    localparam logic [SEL_W-1:0] SEL_CH3 = 3'b010;
    localparam logic [SEL_W-1:0] SEL_CH4 = 3'b011;
    localparam logic [SEL_W-1:0] SEL_CH5 = 3'b100;
    localparam logic [SEL_W-1:0] SEL_CH6 = 3'b101;
    localparam logic [SEL_W-1:0] SEL_CH7 = 3'b110;
    localparam logic [SEL_W-1:0] SEL_CH8 = 3'b111;

    // Channel index arithmetic wraps naturally at 8.
    function automatic logic [SEL_W-1:0] idx_next(
        input logic [SEL_W-1:0] idx
    );
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_mux8to1_16bit_if.sv
// Producer/consumer bundle for the round-robin collector.
// slave is the collector side, master the environment side.
interface rr_mux8to1_16bit_if
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic [WIDTH-1:0] in5;
    logic [WIDTH-1:0] in6;
    logic [WIDTH-1:0] in7;
    logic [WIDTH-1:0] in8;
    logic [N_CH-1:0]  in_valid;
    logic [N_CH-1:0]  in_ready;
    logic [WIDTH-1:0] out;
    logic [SEL_W-1:0] out_sel;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in1, in2, in3, in4, in5, in6, in7, in8,
        input  in_valid,
        output in_ready,
        output out, out_sel, out_valid,
        input  out_ready
    );

    modport master (
        output in1, in2, in3, in4, in5, in6, in7, in8,
        output in_valid,
        input  in_ready,
        input  out, out_sel, out_valid,
        output out_ready
    );

endinterface

// File: rtl/rr_arbiter8.sv
// Rotating-priority arbiter over eight requesters.
// ptr names the index with highest priority this cycle.
module rr_arbiter8
    import mux_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cand;

    // Scan from the far end back to ptr so the nearest request wins.
    always_comb begin
        grant_idx = ptr;
        cand      = ptr;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                grant_idx = cand;
            end
        end
        any = |req;
    end

    // Move priority just past the winner on every accepted word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= idx_next(grant_idx);
        end
    end

endmodule

// File: rtl/rr_mux8to1_16bit.sv
// Eight-channel round-robin collector with one output register.
// Each word carries its source index in demux select encoding.
module rr_mux8to1_16bit
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                reset_n,
    rr_mux8to1_16bit_if.slave  bus
);

    logic             load_ok;
    logic             load;
    logic             any;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] data_sel;

    assign load_ok = !bus.out_valid || bus.out_ready;
    assign load    = load_ok && any && reset_n;

    rr_arbiter8 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (bus.in_valid),
        .advance   (load),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Route the granted channel's data toward the output register.
    always_comb begin
        data_sel = '0;
        unique case (grant_idx)
            SEL_CH1: data_sel = bus.in1;
            SEL_CH2: data_sel = bus.in2;
            SEL_CH3: data_sel = bus.in3;
            SEL_CH4: data_sel = bus.in4;
            SEL_CH5: data_sel = bus.in5;
            SEL_CH6: data_sel = bus.in6;
            SEL_CH7: data_sel = bus.in7;
            SEL_CH8: data_sel = bus.in8;
        endcase
    end

    // Acknowledge only the winner, and only when the word is taken.
    always_comb begin
        bus.in_ready = '0;
        if (load) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    // A load overrides a drain so the register never bubbles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.out       <= '0;
            bus.out_sel   <= SEL_CH1;
            bus.out_valid <= 1'b0;
        end else if (load) begin
            bus.out       <= data_sel;
            bus.out_sel   <= grant_idx;
            bus.out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux8to1_16bit.sv
// Bench for the round-robin collector.
// A scoreboard queue holds words accepted but not yet consumed.
module tb_rr_mux8to1_16bit;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    rr_mux8to1_16bit_if #(.WIDTH(16)) bus ();

    rr_mux8to1_16bit #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [18:0] sb[$];
    logic        mvalid;
    logic [2:0]  mptr;

    function automatic logic [15:0] chan_data(input int k);
        case (k)
            0: return bus.in1;
            1: return bus.in2;
            2: return bus.in3;
            3: return bus.in4;
            4: return bus.in5;
            5: return bus.in6;
            6: return bus.in7;
            default: return bus.in8;
        endcase
    endfunction

    task automatic set_data(input int k, input logic [15:0] v);
        case (k)
            0: bus.in1 = v;
            1: bus.in2 = v;
            2: bus.in3 = v;
            3: bus.in4 = v;
            4: bus.in5 = v;
            5: bus.in6 = v;
            6: bus.in7 = v;
            default: bus.in8 = v;
        endcase
    endtask

    task automatic fill_pattern();
        for (int k = 1; k <= 8; k++) begin
            set_data(k - 1, 16'(16'h1111 * k));
        end
    endtask

    // One clock: model predicts grant, checks, updates scoreboard.
    task automatic tick();
        logic [7:0]  exp_ready;
        logic [18:0] e;
        logic        ld;
        int          g;
        @(negedge clk);
        exp_ready = '0;
        ld = 1'b0;
        g = 0;
        if (reset_n && (!mvalid || bus.out_ready) && bus.in_valid != 8'h00) begin
            for (int i = 7; i >= 0; i--) begin
                if (bus.in_valid[(int'(mptr) + i) % 8]) g = (int'(mptr) + i) % 8;
            end
            exp_ready[g] = 1'b1;
            ld = 1'b1;
        end
        n_cmp++;
        if (bus.in_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL in_ready: got %h want %h", bus.in_ready, exp_ready);
        end
        n_cmp++;
        if (bus.out_valid !== mvalid) begin
            n_bad++;
            $display("FAIL out_valid: got %b want %b", bus.out_valid, mvalid);
        end
        if (reset_n && mvalid && bus.out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: word consumed but none expected");
            end else begin
                e = sb.pop_front();
                if ({bus.out, bus.out_sel} !== e) begin
                    n_bad++;
                    $display("FAIL consumed word: got %h/%0d want %h/%0d",
                             bus.out, bus.out_sel, e[18:3], e[2:0]);
                end
            end
        end
        if (!reset_n) begin
            sb.delete();
            mvalid = 1'b0;
            mptr = 3'd0;
        end else if (ld) begin
            sb.push_back({chan_data(g), 3'(g)});
            mvalid = 1'b1;
            mptr = 3'(g + 1);
        end else if (bus.out_ready) begin
            mvalid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.in_valid = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.in_valid = 8'hFF;
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.out !== 16'h0 || bus.out_sel !== 3'd0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset state: out=%h sel=%0d valid=%b",
                     bus.out, bus.out_sel, bus.out_valid);
        end
        n_cmp++;
        if (bus.in_ready !== 8'h00) begin
            n_bad++;
            $display("FAIL reset in_ready: got %h want 00", bus.in_ready);
        end
        bus.in_valid = 8'h00;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_data(2, 16'hA5A5);
        bus.in_valid = 8'h04;
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 8'h04) begin
            n_bad++;
            $display("FAIL single in_ready: got %h want 04", bus.in_ready);
        end
        tick();
        bus.in_valid = 8'h00;
        n_cmp++;
        if (bus.out !== 16'hA5A5 || bus.out_sel !== 3'b010 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single word: got %h/%0d/%b want a5a5/2/1",
                     bus.out, bus.out_sel, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_all_valid();
        do_reset();
        fill_pattern();
        bus.in_valid = 8'hFF;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'(c % 8)) begin
                n_bad++;
                $display("FAIL rotation step %0d: sel=%0d valid=%b want sel=%0d valid=1",
                         c, bus.out_sel, bus.out_valid, c % 8);
            end
        end
        bus.in_valid = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        logic [2:0]  held_sel;
        do_reset();
        fill_pattern();
        bus.in_valid = 8'hFF;
        bus.out_ready = 1'b0;
        tick();
        held = bus.out;
        held_sel = bus.out_sel;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (bus.out !== 16'h1111 || held_sel !== 3'd0 ||
                bus.out !== held || bus.out_sel !== held_sel) begin
                n_bad++;
                $display("FAIL backpressure hold %0d: got %h/%0d want 1111/0",
                         c, bus.out, bus.out_sel);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 8'h02) begin
            n_bad++;
            $display("FAIL release grant: got %h want 02", bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.out !== 16'h2222 || bus.out_sel !== 3'd1) begin
            n_bad++;
            $display("FAIL after release: got %h/%0d want 2222/1", bus.out, bus.out_sel);
        end
        bus.in_valid = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_sparse();
        do_reset();
        fill_pattern();
        bus.out_ready = 1'b1;
        bus.in_valid = 8'h20;
        tick();
        bus.in_valid = 8'h09;
        tick();
        n_cmp++;
        if (bus.out_sel !== 3'd0 || bus.out !== 16'h1111) begin
            n_bad++;
            $display("FAIL sparse wrap: got %h/%0d want 1111/0", bus.out, bus.out_sel);
        end
        tick();
        n_cmp++;
        if (bus.out_sel !== 3'd3 || bus.out !== 16'h4444) begin
            n_bad++;
            $display("FAIL sparse skip: got %h/%0d want 4444/3", bus.out, bus.out_sel);
        end
        bus.in_valid = 8'h00;
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        set_data(5, 16'hBEEF);
        bus.out_ready = 1'b1;
        bus.in_valid = 8'h20;
        tick();
        bus.in_valid = 8'h00;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out !== 16'hBEEF || bus.out_sel !== 3'd5) begin
            n_bad++;
            $display("FAIL drain load: got %h/%0d/%b want beef/5/1",
                     bus.out, bus.out_sel, bus.out_valid);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL drain empty: got %h/%b want beef/0", bus.out, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_pattern();
        bus.in_valid = 8'hFF;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out !== 16'h0 || bus.out_sel !== 3'd0) begin
            n_bad++;
            $display("FAIL mid reset: got %h/%0d/%b want 0/0/0",
                     bus.out, bus.out_sel, bus.out_valid);
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 8'h01) begin
            n_bad++;
            $display("FAIL first grant after reset: got %h want 01", bus.in_ready);
        end
        tick();
        n_cmp++;
        if (bus.out !== 16'h1111 || bus.out_sel !== 3'd0) begin
            n_bad++;
            $display("FAIL post-reset word: got %h/%0d want 1111/0", bus.out, bus.out_sel);
        end
        bus.in_valid = 8'h00;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.in_valid = 8'h00;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) set_data(k, 16'h0);
        mvalid = 1'b0;
        mptr = 3'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_valid();
        test_backpressure();
        test_sparse();
        test_drain();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover words: got %0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
